vec_exec_unit: RTL and testbench
================================

// Module: vec_exec_unit
// PURPOSE
//   Parametrised multi-cycle vector execution unit for the ARM core's vector extension.
//   Owns NVREG vector registers of LANES x WIDTH bits. Executes one element-wise op per
//   start request, processing LPC lanes per cycle. Handshakes busy/done with the core
//   controller so the core stalls instead of relying on a single-cycle vector write.
// PARAMETERS
//   WIDTH  32  lane width in bits
//   LANES  5   lanes per vector register
//   LPC    1   lanes processed per cycle; 1 <= LPC <= LANES; need not divide LANES
//   NVREG  8   number of vector registers; power of 2, >= 2
// PORTS
//   clk          in   1               rising-edge clock
//   reset        in   1               asynchronous, active-low reset
//   start        in   1               request; sampled only in IDLE
//   op           in   3               vec_op_t: ADD=0 SUB=1 AND=2 ORR=3 BCAST=4; 5..7 illegal
//   vd,vn,vm     in   $clog2(NVREG)   destination and source register indices
//   scalar       in   WIDTH           broadcast operand for BCAST
//   rd_sel       in   $clog2(NVREG)   read-port register index
//   rd_data      out  LANES*WIDTH     combinational read of register rd_sel; lane i at [i*WIDTH +: WIDTH]
//   busy         out  1               high while an op is in flight
//   done         out  1               one-cycle completion pulse
//   err          out  1               with done: illegal op, no write performed
//   sat_hit      out  1               with done: some lane saturated (VEC_SAT_EN only)
// BEHAVIOUR
//   Reset (async assert, sync release): FSM to IDLE; all registers, snapshots and lane counter to 0;
//     busy=done=err=sat_hit=0. Reset mid-op aborts; partial writes are lost (registers cleared).
//   FSM: IDLE -(start)-> EXEC -(last lane group)-> DONE -> IDLE.
//   Start accepted in IDLE: latch op, vd, scalar; snapshot full vn and vm vectors.
//     In-place ops (vd==vn or vd==vm) therefore use pre-op values.
//   start outside IDLE: ignored, no queueing.
//   EXEC: N = ceil(LANES/LPC) cycles. Cycle k writes lanes [k*LPC, min((k+1)*LPC, LANES)) of vd.
//     Last group is partial when LPC does not divide LANES.
//   DONE: done=1 for exactly one cycle; all lanes of vd are then visible on rd_data.
//   busy: 1 from the cycle after start is accepted through the DONE cycle.
//   Latency: start sampled at edge 0 -> done high in cycle N+1. Next start is accepted in the cycle after DONE.
//   ADD/SUB: modulo 2^WIDTH per lane; no carries between lanes.
//   AND/ORR: bitwise per lane. BCAST: every lane of vd = scalar; vn/vm ignored.
//   Illegal op 5..7: EXEC still runs N cycles with no writes; err=1 with done.
//   rd_data is purely combinational from the register array.
//     If rd_sel==vd during EXEC, already-written lanes show new values.
// CONFIGURATION
//   VEC_SAT_EN defined:
//     ADD/SUB saturate as signed WIDTH-bit values: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
//     sat_hit is 1 with done if any lane clamped; sticky across the op, cleared on accept.
//   VEC_SAT_EN undefined: wrap-around arithmetic; sat_hit tied to 0.
// STRUCTURE
//   Package vec_pkg:
//     vec_op_t enum; vec_state_t enum {IDLE, EXEC, DONE}.
//     Function lane_groups(LANES, LPC) = ceil division.
//   Sub-module vec_lane_alu:
//     One lane; inputs op/a/b/scalar; outputs result and sat.
//     Instantiated LPC times in a generate loop.
//     Lane mux selects snapshot lanes by counter*LPC + j; out-of-range j (partial group) is write-disabled.
// TESTING
//   T1 reset mid-EXEC (LANES=5, LPC=1, cycle 2) -> all regs 0, busy=0, done never pulses.
//   T2 BCAST vd=1 scalar=0x12345678 -> done at cycle 6; rd_sel=1 gives 5 lanes of 0x12345678.
//   T3 ADD v2=v1+v1 with v1 lanes 0xFFFFFFFF -> lanes 0xFFFFFFFE; VEC_SAT_EN: 0xFFFFFFFE (-2, no clamp).
//   T4 SAT: 0x7FFFFFFF+1 -> 0x80000000 without macro; 0x7FFFFFFF and sat_hit=1 with VEC_SAT_EN.
//   T5 LPC=2, LANES=5, in-place SUB v3=v3-v4 -> done at cycle 4; pre-op v3 used in all lanes.
//   T6 op=6 -> err=1 with done, no register changes; start pulsed while busy is ignored.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector execution unit.
//   vec_op_t     : element-wise opcode (3 bits; encodings 5..7 are illegal)
//   vec_state_t  : control FSM states
//   lane_groups  : number of EXEC cycles for a given lane count and lanes-per-cycle
//   op_legal     : true for encodings the unit actually executes
package vec_pkg;

  typedef enum logic [2:0] {
    OpAdd   = 3'd0,
    OpSub   = 3'd1,
    OpAnd   = 3'd2,
    OpOrr   = 3'd3,
    OpBcast = 3'd4
  } vec_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } vec_state_t;

  function automatic int unsigned lane_groups(input int unsigned lanes, input int unsigned lpc);
    return (lanes + lpc - 1) / lpc;
  endfunction

  function automatic logic op_legal(input vec_op_t op);
    return op <= OpBcast;
  endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Core-controller <-> vector execution unit bundle.
//   master : core side (drives start/op/vd/vn/vm/scalar/rd_sel, observes status and rd_data)
//   slave  : execution unit side
interface vec_exec_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 5,
  parameter int unsigned NVREG = 8
);
  localparam int unsigned VW = $clog2(NVREG);

  logic                   start;
  logic [2:0]             op;
  logic [VW-1:0]          vd;
  logic [VW-1:0]          vn;
  logic [VW-1:0]          vm;
  logic [WIDTH-1:0]       scalar;
  logic [VW-1:0]          rd_sel;
  logic [LANES*WIDTH-1:0] rd_data;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   sat_hit;

  modport master (
    output start, op, vd, vn, vm, scalar, rd_sel,
    input  rd_data, busy, done, err, sat_hit
  );

  modport slave (
    input  start, op, vd, vn, vm, scalar, rd_sel,
    output rd_data, busy, done, err, sat_hit
  );
endinterface

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU of the vector execution unit.
// Build option: VEC_SAT_EN -> ADD/SUB saturate as signed WIDTH-bit values and flag sat;
//               otherwise ADD/SUB wrap and sat is always 0.
// Ports:
//   op     : operation (illegal encodings give result 0, sat 0)
//   a, b   : source lanes (vn, vm snapshots)
//   scalar : broadcast operand
//   result : lane result
//   sat    : lane clamped this cycle
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  vec_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] scalar,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

`ifdef VEC_SAT_EN
  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_add;
  logic ovf_sub;

  // Signed overflow: operands agree (add) / disagree (sub) in sign and result sign flips.
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`endif

  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (op)
      OpAdd: begin
        result = sum;
`ifdef VEC_SAT_EN
        if (ovf_add) begin
          result = a[WIDTH-1] ? MinNeg : MaxPos;
          sat    = 1'b1;
        end
`endif
      end
      OpSub: begin
        result = diff;
`ifdef VEC_SAT_EN
        if (ovf_sub) begin
          result = a[WIDTH-1] ? MinNeg : MaxPos;
          sat    = 1'b1;
        end
`endif
      end
      OpAnd:   result = a & b;
      OpOrr:   result = a | b;
      OpBcast: result = scalar;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution unit: NVREG registers of LANES x WIDTH bits, one element-wise
// op per start, LPC lanes written per EXEC cycle, busy/done handshake with the core.
// Build option: VEC_SAT_EN enables signed saturation for ADD/SUB and the sat_hit flag.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : vec_exec_unit_if.slave (start/op/vd/vn/vm/scalar/rd_sel in,
//           rd_data/busy/done/err/sat_hit out)
module vec_exec_unit
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 5,
  parameter int unsigned LPC   = 1,
  parameter int unsigned NVREG = 8
) (
  input logic           clk,
  input logic           reset,
  vec_exec_unit_if.slave bus
);

  localparam int unsigned NGRP = lane_groups(LANES, LPC);
  localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned VW   = $clog2(NVREG);
  localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [WIDTH-1:0] lane_t;

  vec_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  vec_op_t       op_q;
  logic [VW-1:0] vd_q;
  lane_t         scalar_q;
  lane_t         snap_n_q [LANES];
  lane_t         snap_m_q [LANES];
  lane_t         regs_q   [NVREG][LANES];
  logic          sat_q;

  lane_t         res    [LPC];
  logic          lsat   [LPC];
  logic [LW-1:0] lsel   [LPC];
  logic          lvalid [LPC];

  logic accept, exec, last_grp, wr_en;

  assign accept   = (state_q == StIdle) && bus.start;
  assign exec     = (state_q == StExec);
  assign last_grp = (cnt_q == CW'(NGRP - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StExec;
      StExec:  if (last_grp)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy    = (state_q != StIdle);
    bus.done    = (state_q == StDone);
    bus.err     = (state_q == StDone) && !op_legal(op_q);
    bus.sat_hit = (state_q == StDone) && sat_q;
    wr_en       = exec && op_legal(op_q);
  end

  // Lane j of the current group; lanes past LANES in a partial last group are write-disabled.
  always_comb begin
    for (int j = 0; j < int'(LPC); j++) begin
      int unsigned idx;
      idx       = int'(cnt_q) * LPC + j;
      lvalid[j] = (idx < LANES);
      lsel[j]   = lvalid[j] ? LW'(idx) : '0;
    end
  end

  for (genvar j = 0; j < int'(LPC); j++) begin : g_lane
    vec_lane_alu #(
      .WIDTH(WIDTH)
    ) u_alu (
      .op    (op_q),
      .a     (snap_n_q[lsel[j]]),
      .b     (snap_m_q[lsel[j]]),
      .scalar(scalar_q),
      .result(res[j]),
      .sat   (lsat[j])
    );
  end

  // Datapath: operand capture on accept, lane-group writeback during EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= OpAdd;
      vd_q     <= '0;
      scalar_q <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        snap_n_q[i] <= '0;
        snap_m_q[i] <= '0;
      end
      for (int r = 0; r < int'(NVREG); r++) begin
        for (int i = 0; i < int'(LANES); i++) regs_q[r][i] <= '0;
      end
    end else begin
      if (accept) begin
        op_q     <= vec_op_t'(bus.op);
        vd_q     <= bus.vd;
        scalar_q <= bus.scalar;
        cnt_q    <= '0;
        sat_q    <= 1'b0;
        // Full snapshot so in-place ops see pre-op source values in every lane.
        for (int i = 0; i < int'(LANES); i++) begin
          snap_n_q[i] <= regs_q[bus.vn][i];
          snap_m_q[i] <= regs_q[bus.vm][i];
        end
      end
      if (exec) begin
        cnt_q <= last_grp ? '0 : cnt_q + CW'(1);
        for (int j = 0; j < int'(LPC); j++) begin
          if (wr_en && lvalid[j]) begin
            regs_q[vd_q][lsel[j]] <= res[j];
            if (lsat[j]) sat_q <= 1'b1;
          end
        end
      end
    end
  end

  // Combinational read port; lane i at [i*WIDTH +: WIDTH].
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      bus.rd_data[i*WIDTH +: WIDTH] = regs_q[bus.rd_sel][i];
    end
  end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit: table-driven op vectors on an LPC=1 instance plus
// directed sequences (in-flight visibility, start-while-busy, reset mid-EXEC, LPC=2 in-place).
module tb_vec_exec_unit;

`ifdef VEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  vec_exec_unit_if #(.WIDTH(32), .LANES(5), .NVREG(8)) if1 ();
  vec_exec_unit_if #(.WIDTH(32), .LANES(5), .NVREG(8)) if2 ();

  vec_exec_unit #(.WIDTH(32), .LANES(5), .LPC(1), .NVREG(8)) u_dut1 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if1)
  );

  vec_exec_unit #(.WIDTH(32), .LANES(5), .LPC(2), .NVREG(8)) u_dut2 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  vd;
    logic [2:0]  vn;
    logic [2:0]  vm;
    logic [31:0] scalar;
    logic [31:0] exp;
    logic        exp_err;
    logic        exp_sat;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] vec_of(input logic [31:0] x);
    return {5{x}};
  endfunction

  task automatic run_op1(input logic [2:0] op, input logic [2:0] vd, input logic [2:0] vn,
                         input logic [2:0] vm, input logic [31:0] sc,
                         output int cyc, output logic e, output logic s);
    if1.start = 1'b1; if1.op = op; if1.vd = vd; if1.vn = vn; if1.vm = vm; if1.scalar = sc;
    tick();
    if1.start = 1'b0;
    cyc = 1;
    while (!if1.done && cyc < 40) begin
      tick();
      cyc++;
    end
    e = if1.err;
    s = if1.sat_hit;
    tick();
  endtask

  task automatic run_op2(input logic [2:0] op, input logic [2:0] vd, input logic [2:0] vn,
                         input logic [2:0] vm, input logic [31:0] sc, output int cyc);
    if2.start = 1'b1; if2.op = op; if2.vd = vd; if2.vn = vn; if2.vm = vm; if2.scalar = sc;
    tick();
    if2.start = 1'b0;
    cyc = 1;
    while (!if2.done && cyc < 40) begin
      tick();
      cyc++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic e, s;
    int   done_seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if1.start = 1'b0; if1.op = '0; if1.vd = '0; if1.vn = '0; if1.vm = '0;
    if1.scalar = '0; if1.rd_sel = '0;
    if2.start = 1'b0; if2.op = '0; if2.vd = '0; if2.vn = '0; if2.vm = '0;
    if2.scalar = '0; if2.rd_sel = '0;

    // op, vd, vn, vm, scalar, expected lane value of vd, err, sat_hit
    tbl[0]  = '{3'd4, 3'd1, 3'd0, 3'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    tbl[1]  = '{3'd4, 3'd1, 3'd0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[2]  = '{3'd0, 3'd2, 3'd1, 3'd1, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3]  = '{3'd4, 3'd3, 3'd0, 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 3'd4, 3'd0, 3'd0, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    tbl[5]  = '{3'd0, 3'd5, 3'd3, 3'd4, 32'h0,
                SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, SAT};
    tbl[6]  = '{3'd1, 3'd6, 3'd4, 3'd3, 32'h0,        32'h80000002, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 3'd6, 3'd2, 3'd3, 32'h0,
                SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b0, SAT};
    tbl[8]  = '{3'd2, 3'd7, 3'd1, 3'd3, 32'h0,        32'h7FFFFFFF, 1'b0, 1'b0};
    tbl[9]  = '{3'd3, 3'd7, 3'd4, 3'd2, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 3'd4, 3'd4, 3'd4, 32'h0,        32'h00000002, 1'b0, 1'b0};
    tbl[11] = '{3'd6, 3'd4, 3'd1, 3'd1, 32'hAAAAAAAA, 32'h00000002, 1'b1, 1'b0};
    tbl[12] = '{3'd1, 3'd0, 3'd3, 3'd4, 32'h0,        32'h7FFFFFFD, 1'b0, 1'b0};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("reset_busy", 160'(if1.busy), 160'(0));
    chk("reset_done", 160'(if1.done), 160'(0));
    chk("reset_err", 160'(if1.err), 160'(0));
    chk("reset_sat", 160'(if1.sat_hit), 160'(0));
    for (int r = 0; r < 8; r++) begin
      if1.rd_sel = 3'(r);
      #1;
      chk($sformatf("reset_reg%0d", r), if1.rd_data, 160'(0));
    end

    // Table-driven ops on the LPC=1 instance (N=5, done in cycle 6)
    for (int i = 0; i < 13; i++) begin
      run_op1(tbl[i].op, tbl[i].vd, tbl[i].vn, tbl[i].vm, tbl[i].scalar, cyc, e, s);
      chk($sformatf("v%0d_latency", i), 160'(cyc), 160'(6));
      chk($sformatf("v%0d_err", i), 160'(e), 160'(tbl[i].exp_err));
      chk($sformatf("v%0d_sat", i), 160'(s), 160'(tbl[i].exp_sat));
      chk($sformatf("v%0d_done_1cyc", i), 160'(if1.done), 160'(0));
      chk($sformatf("v%0d_idle", i), 160'(if1.busy), 160'(0));
      if1.rd_sel = tbl[i].vd;
      #1;
      chk($sformatf("v%0d_data", i), if1.rd_data, vec_of(tbl[i].exp));
    end

    // In-flight visibility of vd, and start while busy is dropped
    if1.rd_sel = 3'd7;
    if1.start = 1'b1; if1.op = 3'd4; if1.vd = 3'd7; if1.scalar = 32'h11111111;
    tick();
    if1.start = 1'b0;
    chk("flight_busy", 160'(if1.busy), 160'(1));
    chk("flight_cyc1", if1.rd_data, vec_of(32'hFFFFFFFF));
    tick();
    chk("flight_cyc2", if1.rd_data, {{4{32'hFFFFFFFF}}, 32'h11111111});
    if1.start = 1'b1; if1.op = 3'd4; if1.vd = 3'd6; if1.scalar = 32'hDEADBEEF;
    tick();
    if1.start = 1'b0;
    cyc = 0;
    while (!if1.done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("flight_done_seen", 160'(if1.done), 160'(1));
    tick();
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (if1.done) done_seen++;
      tick();
    end
    chk("busy_start_ignored_done", 160'(done_seen), 160'(0));
    chk("flight_final", if1.rd_data, vec_of(32'h11111111));
    if1.rd_sel = 3'd6;
    #1;
    chk("busy_start_ignored_v6", if1.rd_data, vec_of(SAT ? 32'h80000000 : 32'h7FFFFFFF));

    // Reset in cycle 2 of EXEC aborts and clears everything
    if1.start = 1'b1; if1.op = 3'd0; if1.vd = 3'd5; if1.vn = 3'd1; if1.vm = 3'd1;
    tick();
    if1.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 160'(if1.busy), 160'(0));
    for (int r = 0; r < 8; r++) begin
      if1.rd_sel = 3'(r);
      #1;
      chk($sformatf("abort_reg%0d", r), if1.rd_data, 160'(0));
    end
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if1.done || if1.busy) done_seen++;
    end
    chk("abort_no_done", 160'(done_seen), 160'(0));

    // LPC=2, LANES=5: N=3, done in cycle 4; in-place SUB uses pre-op v3 in every lane
    run_op2(3'd4, 3'd3, 3'd0, 3'd0, 32'd10, cyc);
    chk("lpc2_bcast_latency", 160'(cyc), 160'(4));
    run_op2(3'd4, 3'd4, 3'd0, 3'd0, 32'd3, cyc);
    if2.rd_sel = 3'd3;
    #1;
    chk("lpc2_v3_init", if2.rd_data, vec_of(32'd10));
    run_op2(3'd1, 3'd3, 3'd3, 3'd4, 32'd0, cyc);
    chk("lpc2_sub_latency", 160'(cyc), 160'(4));
    chk("lpc2_inplace_sub", if2.rd_data, vec_of(32'd7));
    if2.rd_sel = 3'd4;
    #1;
    chk("lpc2_v4_kept", if2.rd_data, vec_of(32'd3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
